mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_lane_ctrl.sv | 42 ++++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM states, access size codes and grant IDs for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // Undefined size, or a half/word not on its natural boundary
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SIZE_BAD)
            || ((size == SIZE_WORD) && (lo != 2'b00))
            || ((size == SIZE_HALF) && lo[0]);
    endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// rtl/mem_lane_ctrl.sv - byte-lane enables, write replication, read alignment and misalign detect
module mem_lane_ctrl
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    // Pick lanes by size/offset; narrow reads come back right-aligned and zero-extended
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SIZE_WORD: begin
                o_be = 4'b1111;
            end
            SIZE_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0000, i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0]};
            end
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h000000, i_rdata[{i_addr_lo, 3'b000} +: 8]};
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

    assign o_misalign = size_misaligned(i_size, i_addr_lo);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one RAM port; MEM_ARB_FAIRNESS_EN adds fetch anti-starvation
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              if_stall,
    output logic              d_stall
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1 || ADDR_W < 3) begin : g_bad_cfg
        $error("mem_arbiter: unsupported parameter set");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    grant_t            r_gnt;
    logic [3:0]        r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_if_ready;
    logic              r_d_ready;
    logic              r_d_err;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_idle;
    logic              w_access;
    logic              w_fetch_first;
    logic              w_grant_data;
    logic              w_grant_fetch;
    logic [1:0]        w_lane_size;
    logic [1:0]        w_lane_lo;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_lane_rdata;
    logic              w_misalign;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_access      = (r_state == ST_ACCESS);
    assign w_grant_data  = d_req && !(if_req && w_fetch_first);
    assign w_grant_fetch = if_req && !w_grant_data;

    // While idle the lane logic looks at the live data request to flag misalignment;
    // once granted it works from the latched operands
    assign w_lane_size = w_idle ? d_size : r_size;
    assign w_lane_lo   = w_idle ? d_addr[1:0] : r_addr[1:0];

    mem_lane_ctrl u_lane (
        .i_size     (w_lane_size),
        .i_addr_lo  (w_lane_lo),
        .i_wdata    (r_wdata),
        .i_rdata    (ram_rdata),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_lane_rdata),
        .o_misalign (w_misalign)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] r_starve;

    assign w_fetch_first = (r_starve == STARVE_W'(STARVE_LIMIT));

    // Count data grants that bypassed a waiting fetch; any fetch grant clears it
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_idle) begin
            if (w_grant_data && if_req && !w_fetch_first) begin
                r_starve <= r_starve + 1'b1;
            end else if (w_grant_fetch) begin
                r_starve <= '0;
            end
        end
    end
`else
    assign w_fetch_first = 1'b0;
`endif

    // Grant, hold the RAM port for WAIT_CYCLES, then one response cycle before re-arbitrating
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= GNT_FETCH;
            r_wait     <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_size     <= SIZE_WORD;
            r_we       <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_d_err    <= 1'b0;
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_data) begin
                        r_gnt   <= GNT_DATA;
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        r_size  <= d_size;
                        r_we    <= d_we;
                        r_wait  <= WAIT_LOAD;
                        if (w_misalign) begin
                            r_state   <= ST_RESP;
                            r_d_ready <= 1'b1;
                            r_d_err   <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end else if (w_grant_fetch) begin
                        r_gnt   <= GNT_FETCH;
                        r_addr  <= if_addr;
                        r_wdata <= 32'h0;
                        r_size  <= SIZE_WORD;
                        r_we    <= 1'b0;
                        r_wait  <= WAIT_LOAD;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_wait == 4'd0) begin
                        r_state <= ST_RESP;
                        if (r_gnt == GNT_DATA) begin
                            r_d_rdata <= w_lane_rdata;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= ram_rdata;
                            r_if_ready <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_en    = w_access;
    assign ram_we    = w_access && r_we;
    assign ram_be    = w_access ? w_be : 4'b0000;
    assign ram_addr  = w_access ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign ram_wdata = w_access ? w_lane_wdata : 32'h0;

    assign if_ready = r_if_ready;
    assign if_rdata = r_if_rdata;
    assign d_ready  = r_d_ready;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

    assign if_stall = if_req && !r_if_ready;
    assign d_stall  = d_req && !r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int W     = 2;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ready;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        if_stall;
    logic        d_stall;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .WAIT_CYCLES(W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .if_stall(if_stall), .d_stall(d_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [3:0] exp_be(input bit [1:0] sz, input bit [1:0] lo);
        if (sz == 2'd0) return 4'hF;
        if (sz == 2'd1) return lo[1] ? 4'hC : 4'h3;
        return 4'(1 << lo);
    endfunction

    function automatic bit [31:0] exp_wd(input bit [1:0] sz, input bit [31:0] w);
        if (sz == 2'd0) return w;
        if (sz == 2'd1) return {w[15:0], w[15:0]};
        return {w[7:0], w[7:0], w[7:0], w[7:0]};
    endfunction

    function automatic bit [31:0] exp_align(input bit [31:0] r, input bit [1:0] sz, input bit [1:0] lo);
        if (sz == 2'd0) return r;
        if (sz == 2'd1) return (r >> (16 * lo[1])) & 32'h0000FFFF;
        return (r >> (8 * lo)) & 32'h000000FF;
    endfunction

    // Transaction-level model: each grant books a timeline of edge numbers
    int        n = 0;
    bit        started = 1'b0;
    int        free_at, rdy_at, cap_at, acc_lo, acc_hi;
    int        starve;
    bit        tx_data, tx_err, tx_we;
    bit [1:0]  tx_size;
    bit [31:0] tx_addr, tx_wdata;
    bit [31:0] e_if_rdata, e_d_rdata;

    always @(posedge clock) begin
        n = n + 1;
        if (!reset) begin
            started = 1'b1;
            free_at = n + 1;
            rdy_at = -1;
            cap_at = -1;
            acc_lo = 1;
            acc_hi = 0;
            starve = 0;
            e_if_rdata = 32'h0;
            e_d_rdata = 32'h0;
        end else if (started) begin
            if (n == cap_at) begin
                if (tx_data) e_d_rdata = exp_align(ram_rdata, tx_size, tx_addr[1:0]);
                else e_if_rdata = ram_rdata;
            end
            if (n >= free_at && (if_req || d_req)) begin
                tx_data = d_req && !(if_req && FAIR && starve >= LIMIT);
                if (tx_data) begin
                    if (if_req && starve < LIMIT) starve++;
                    tx_addr = d_addr;
                    tx_size = d_size;
                    tx_we = d_we;
                    tx_wdata = d_wdata;
                    tx_err = (d_size == 2'd3) || (d_size == 2'd0 && d_addr[1:0] != 2'd0)
                          || (d_size == 2'd1 && d_addr[0]);
                end else begin
                    starve = 0;
                    tx_addr = if_addr;
                    tx_size = 2'd0;
                    tx_we = 1'b0;
                    tx_wdata = 32'h0;
                    tx_err = 1'b0;
                end
                if (tx_err) begin
                    acc_lo = 1; acc_hi = 0; cap_at = -1; rdy_at = n; free_at = n + 2;
                end else begin
                    acc_lo = n; acc_hi = n + W - 1; cap_at = n + W; rdy_at = n + W; free_at = n + W + 2;
                end
            end
        end
    end

    always @(negedge clock) begin
        bit en;
        bit rdy;
        if (started) begin
            en = (n >= acc_lo) && (n <= acc_hi);
            rdy = (n == rdy_at);
            chk("ram_en", ram_en, en);
            chk("ram_we", ram_we, en && tx_we);
            chk("ram_be", ram_be, en ? exp_be(tx_size, tx_addr[1:0]) : 4'h0);
            chk("ram_addr", ram_addr, en ? (tx_addr & 32'hFFFFFFFC) : 32'h0);
            if (!en || tx_we) chk("ram_wdata", ram_wdata, en ? exp_wd(tx_size, tx_wdata) : 32'h0);
            chk("if_ready", if_ready, rdy && !tx_data);
            chk("d_ready", d_ready, rdy && tx_data);
            chk("d_err", d_err, rdy && tx_data && tx_err);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("if_stall", if_stall, if_req && !(rdy && !tx_data));
            chk("d_stall", d_stall, d_req && !(rdy && tx_data));
        end
    end

    // Results of the most recent wait for a ready pulse
    int          lat, en_cnt;
    bit          got_if, got_d, got_err, we_bad, ifstall_all, seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd, got_if_rdata, got_d_rdata;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_any();
        got_if = 0; got_d = 0; got_err = 0; lat = 0; en_cnt = 0;
        we_bad = 0; ifstall_all = 1; seen_we = 0; seen_be = 4'h0; seen_wd = 32'h0;
        for (int k = 0; k < 40; k++) begin
            tick();
            lat++;
            if (ram_en) begin
                en_cnt++; seen_be = ram_be; seen_wd = ram_wdata; seen_we = ram_we;
            end else if (ram_we) begin
                we_bad = 1;
            end
            if (!if_stall) ifstall_all = 0;
            if (if_ready || d_ready) begin
                got_if = if_ready; got_d = d_ready; got_err = d_err;
                got_if_rdata = if_rdata; got_d_rdata = d_rdata;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_ready timeout actual=no_ready required=ready within 40 cycles");
    endtask

    task automatic run_fetch(input logic [31:0] a);
        if_addr = a;
        if_req = 1'b1;
        wait_any();
        if_req = 1'b0;
        tick();
    endtask

    task automatic run_data(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        wait_any();
        d_req = 1'b0;
        tick();
    endtask

    bit [9:0] seq;
    int       stray;

    initial begin
        repeat (3) tick();
        chk("lit_reset_en", ram_en, 1'b0);
        chk("lit_reset_resp", {if_ready, d_ready, d_err}, 3'b000);
        chk("lit_reset_rdata", if_rdata | d_rdata, 32'h0);
        reset = 1'b1;
        tick();

        ram_rdata = 32'h8C010004;
        run_fetch(32'h40);
        chk("lit_fetch_lat", lat, 3);
        chk("lit_fetch_rdata", got_if_rdata, 32'h8C010004);
        chk("lit_fetch_en_cycles", en_cnt, 2);
        ram_rdata = 32'h01234567;
        run_fetch(32'h43);
        chk("lit_fetch_unaligned", got_if_rdata, 32'h01234567);

        run_data(1'b1, 2'b10, 32'h103, 32'h000000AB);
        chk("lit_sb_be", seen_be, 4'b1000);
        chk("lit_sb_wdata", seen_wd, 32'hABABABAB);
        chk("lit_sb_we", seen_we, 1'b1);
        chk("lit_sb_we_outside", we_bad, 1'b0);
        run_data(1'b1, 2'b01, 32'h102, 32'h0000BEEF);
        chk("lit_sh_be", seen_be, 4'b1100);
        chk("lit_sh_wdata", seen_wd, 32'hBEEFBEEF);
        run_data(1'b1, 2'b00, 32'h104, 32'h12345678);
        chk("lit_sw_be", seen_be, 4'b1111);

        ram_rdata = 32'h11223344;
        run_data(1'b0, 2'b01, 32'h100, 32'h0);
        chk("lit_lh_lo", got_d_rdata, 32'h00003344);
        run_data(1'b0, 2'b01, 32'h102, 32'h0);
        chk("lit_lh_hi", got_d_rdata, 32'h00001122);
        run_data(1'b0, 2'b10, 32'h101, 32'h0);
        chk("lit_lb_1", got_d_rdata, 32'h00000033);
        run_data(1'b0, 2'b10, 32'h103, 32'h0);
        chk("lit_lb_3", got_d_rdata, 32'h00000011);
        run_data(1'b0, 2'b00, 32'h108, 32'h0);
        chk("lit_lw", got_d_rdata, 32'h11223344);

        run_data(1'b0, 2'b01, 32'h101, 32'h0);
        chk("lit_mis_half_err", {got_d, got_err}, 2'b11);
        chk("lit_mis_half_en", en_cnt, 0);
        chk("lit_mis_half_lat", lat, 1);
        run_data(1'b1, 2'b00, 32'h102, 32'hFFFFFFFF);
        chk("lit_mis_word_err", {got_d, got_err, seen_we}, 3'b110);
        run_data(1'b0, 2'b11, 32'h100, 32'h0);
        chk("lit_bad_size_err", {got_d, got_err}, 2'b11);

        ram_rdata = 32'hCAFEF00D;
        d_we = 1'b0; d_size = 2'b00; d_addr = 32'h200; if_addr = 32'h80;
        d_req = 1'b1; if_req = 1'b1;
        wait_any();
        chk("lit_both_first_data", {got_d, got_if}, 2'b10);
        chk("lit_both_if_stall", ifstall_all, 1'b1);
        d_req = 1'b0;
        wait_any();
        chk("lit_both_then_fetch", got_if, 1'b1);
        if_req = 1'b0;
        tick();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        d_we = 1'b0; d_size = 2'b00; d_addr = 32'h300; if_addr = 32'h400;
        d_req = 1'b1; if_req = 1'b1;
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            wait_any();
            seq[i] = got_if;
        end
        d_req = 1'b0; if_req = 1'b0;
        tick();
        tick();
        chk("lit_fair_sequence", seq, FAIR ? 10'b1000010000 : 10'b0000000000);

        if_addr = 32'h500;
        if_req = 1'b1;
        tick();
        chk("lit_rst_access", ram_en, 1'b1);
        tick();
        reset = 1'b0;
        if_req = 1'b0;
        tick();
        chk("lit_rst_en_low", ram_en, 1'b0);
        chk("lit_rst_no_ready", if_ready, 1'b0);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if_ready || d_ready || ram_en) stray++;
        end
        chk("lit_rst_quiet", stray, 0);
        ram_rdata = 32'h0BADF00D;
        run_fetch(32'h504);
        chk("lit_rst_recover_lat", lat, 3);
        chk("lit_rst_recover_rdata", got_if_rdata, 32'h0BADF00D);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
